sdram_port_arbiter: RTL

- Parametrised N-channel front end for sdram_ctrl: round-robin arbitration of read/write requests from `channels` requestors onto the single controller request port.
- Tracks outstanding reads in an in-order tag FIFO and routes each returned read word to the channel that issued it.
- Sits between pixel/host/DMA masters and the sdram_ctrl instance inside the per-chip SDRAM top.

---
 rtl/sdram_arb_pkg.sv | 32 +++
 rtl/sdram_tag_fifo.sv | 52 +++++
 rtl/sdram_port_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and the round-robin pick function for the SDRAM port arbiter.
// Channel indices are sized for the largest supported channel count (8).
package sdram_arb_pkg;

   localparam int unsigned max_channels = 8;
   localparam int unsigned ch_idx_width = $clog2(max_channels);

   typedef logic [ch_idx_width-1:0] ch_idx_t;

   typedef struct packed {
      logic    valid;
      ch_idx_t idx;
   } grant_t;

   // First set bit of req at or after ptr, wrapping modulo n (only bits below n count).
   function automatic grant_t rr_pick(input logic [max_channels-1:0] req,
                                      input ch_idx_t ptr,
                                      input int unsigned n);
      grant_t      g;
      int unsigned k;
      g = '0;
      for (int unsigned i = 0; i < max_channels; i++) begin
         k = (32'(ptr) + i) % n;
         if (i < n && !g.valid && req[ch_idx_t'(k)]) begin
            g.valid = 1'b1;
            g.idx   = ch_idx_t'(k);
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order FIFO of channel tags for outstanding reads.
// Circular buffer; depth must be a power of two so the pointers wrap naturally.
module sdram_tag_fifo #(
   parameter int unsigned depth = 4,
   parameter int unsigned width = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [width-1:0] head
);

   localparam int unsigned ptr_width = (depth > 1) ? $clog2(depth) : 1;

   logic [width-1:0]   mem [depth];
   logic [ptr_width-1:0] wr_ptr;
   logic [ptr_width-1:0] rd_ptr;
   logic [ptr_width:0]   count;
   logic                 do_push;
   logic                 do_pop;

   // A push while full is dropped even if a pop happens in the same cycle.
   always_comb begin
      full    = (count == (ptr_width + 1)'(depth));
      empty   = (count == '0);
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      head    = mem[rd_ptr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin N-channel front end for sdram_ctrl, with in-order read-return routing.
// Handshake: a channel holds r/w valid until it sees ch_ready_o high; acceptance is zero-latency.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned channels        = 4,
   parameter int unsigned addr_width      = 24,
   parameter int unsigned bus_width       = 16,
   parameter int unsigned max_outstanding = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [channels*addr_width-1:0] ch_addr_i,
   input  logic [channels-1:0]           ch_r_valid_i,
   input  logic [channels-1:0]           ch_w_valid_i,
   input  logic [channels*bus_width-1:0] ch_write_i,
   output logic [channels-1:0]           ch_ready_o,
   output logic [channels-1:0]           ch_r_valid_o,
   output logic [bus_width-1:0]          ch_read_o,
   input  logic                          mem_enabled_i,
   input  logic                          mem_data_ready_i,
   output logic [addr_width-1:0]         mem_addr_o,
   output logic                          mem_r_valid_o,
   output logic                          mem_w_valid_o,
   output logic [bus_width-1:0]          mem_write_o,
   input  logic                          mem_r_valid_i,
   input  logic [bus_width-1:0]          mem_read_i,
   output logic                          err_o
);

   logic [channels-1:0]     req;
   logic [max_channels-1:0] req_ext;
   grant_t                  pick;
   logic                    gnt_valid;
   logic                    go;
   logic                    rw_conflict;
   ch_idx_t                 rr_ptr;
   ch_idx_t                 head_tag;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    pop;

   // Grant is also gated by reset so every request-side output drops the moment reset asserts.
   always_comb begin
      req                   = ch_w_valid_i | (ch_r_valid_i & {channels{~fifo_full}});
      req_ext               = '0;
      req_ext[channels-1:0] = req;
      pick                  = rr_pick(req_ext, rr_ptr, channels);
      gnt_valid             = pick.valid & rst_ni;
      go                    = gnt_valid & mem_enabled_i & mem_data_ready_i;
      mem_addr_o            = '0;
      mem_write_o           = '0;
      mem_w_valid_o         = 1'b0;
      mem_r_valid_o         = 1'b0;
      ch_ready_o            = '0;
      rw_conflict           = 1'b0;
      for (int unsigned k = 0; k < channels; k++) begin
         if (gnt_valid && pick.idx == ch_idx_t'(k)) begin
            mem_addr_o    = ch_addr_i[k*addr_width +: addr_width];
            mem_write_o   = ch_write_i[k*bus_width +: bus_width];
            mem_w_valid_o = go & ch_w_valid_i[k];
            mem_r_valid_o = go & ~ch_w_valid_i[k] & ch_r_valid_i[k];
            rw_conflict   = go & ch_w_valid_i[k] & ch_r_valid_i[k];
            ch_ready_o[k] = go;
         end
      end
      pop = mem_r_valid_i & ~fifo_empty;
   end

   sdram_tag_fifo #(
      .depth (max_outstanding),
      .width (ch_idx_width)
   ) u_tag_fifo (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .push      (mem_r_valid_o),
      .push_data (pick.idx),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head_tag)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr       <= '0;
         ch_r_valid_o <= '0;
         ch_read_o    <= '0;
         err_o        <= 1'b0;
      end else begin
         if (go) begin
            rr_ptr <= (pick.idx == ch_idx_t'(channels - 1)) ? '0 : pick.idx + 1'b1;
         end
         // Orphan returns and r+w on one channel are both protocol violations.
         if (rw_conflict || (mem_r_valid_i && fifo_empty)) err_o <= 1'b1;
         for (int unsigned k = 0; k < channels; k++) begin
            ch_r_valid_o[k] <= pop && (head_tag == ch_idx_t'(k));
         end
         if (pop) ch_read_o <= mem_read_i;
      end
   end

endmodule
